// File: rtl/mult_div_unit.sv
// Sequential signed 32x32 multiply (radix-2 Booth) / divide (restoring) unit with HI/LO result registers.
// Latency: 33 cycles start-edge to IDLE; HI/LO/done update on edge 32; divide-by-zero completes after 1 cycle.
// Backpressure: start is honoured only in IDLE; starts while busy are dropped, never queued.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;

  // Operation context captured at the start edge.
  logic        r_op;
  logic        r_neg_q;
  logic        r_neg_r;
  logic [31:0] r_m;
  logic [5:0]  r_cnt;

  // Shared working registers.
  // Multiply: r_acc is the Booth accumulator carried one bit wider than the
  //           32-bit architectural acc so that subtracting M = -2^31 cannot
  //           overflow; r_q is the multiplier, r_q1 the Booth guard bit.
  // Divide:   r_acc is the 33-bit partial remainder, r_q shifts dividend
  //           magnitude bits out at the top and quotient bits in at the bottom.
  logic [32:0] r_acc;
  logic [31:0] r_q;
  logic        r_q1;

  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_busy;
  logic        r_done;
  logic        r_dz;

  logic        w_accept;
  logic        w_dz_start;
  logic        w_last;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;

  logic [32:0] w_m_ext;
  logic [32:0] w_booth_sum;
  logic [32:0] w_booth_acc;
  logic [31:0] w_booth_q;

  logic [32:0] w_shift_rem;
  logic [32:0] w_trial;
  logic        w_fits;
  logic [32:0] w_div_acc;
  logic [31:0] w_div_q;

  logic [32:0] w_acc_nx;
  logic [31:0] w_q_nx;
  logic [31:0] w_rem_mag;
  logic [31:0] w_hi_res;
  logic [31:0] w_lo_res;

  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_dz_start = w_accept && op && (B == 32'd0);
  assign w_last     = (r_state == S_RUN) && (r_cnt == 6'd31);

  // Magnitudes for the divider; -0x80000000 wraps to 0x80000000, which is the
  // correct unsigned magnitude.
  assign w_a_mag = A[31] ? (32'd0 - A) : A;
  assign w_b_mag = B[31] ? (32'd0 - B) : B;

  // Booth step: add/subtract M according to {Q[0], q_1}, then arithmetic shift right.
  always_comb begin
    w_m_ext     = {r_m[31], r_m};
    w_booth_sum = r_acc;
    case ({r_q[0], r_q1})
      2'b01:   w_booth_sum = r_acc + w_m_ext;
      2'b10:   w_booth_sum = r_acc - w_m_ext;
      default: w_booth_sum = r_acc;
    endcase
    w_booth_acc = {w_booth_sum[32], w_booth_sum[32:1]};
    w_booth_q   = {w_booth_sum[0], r_q[31:1]};
  end

  // Restoring division step: shift in the next dividend bit, trial-subtract the divisor.
  always_comb begin
    w_shift_rem = {r_acc[31:0], r_q[31]};
    w_trial     = w_shift_rem - {1'b0, r_m};
    w_fits      = ~w_trial[32];
    w_div_acc   = w_fits ? w_trial : w_shift_rem;
    w_div_q     = {r_q[30:0], w_fits};
  end

  // Select the iteration result and apply divide sign correction for the final write.
  always_comb begin
    w_acc_nx  = r_op ? w_div_acc : w_booth_acc;
    w_q_nx    = r_op ? w_div_q   : w_booth_q;
    w_rem_mag = w_acc_nx[31:0];
    w_hi_res  = w_rem_mag;
    w_lo_res  = w_q_nx;
    if (r_op) begin
      if (r_neg_r) w_hi_res = 32'd0 - w_rem_mag;
      if (r_neg_q) w_lo_res = 32'd0 - w_q_nx;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nx = (op && (B == 32'd0)) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (r_cnt == 6'd31) w_state_nx = S_DONE;
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Status flags registered from the next state so outputs come straight from flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dz   <= 1'b0;
    end else begin
      r_busy <= (w_state_nx != S_IDLE);
      r_done <= (w_state_nx == S_DONE);
      r_dz   <= w_dz_start;
    end
  end

  // Datapath: capture operands on start, iterate in RUN, commit HI/LO on the last iteration.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op    <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_m     <= 32'd0;
      r_cnt   <= 6'd0;
      r_acc   <= 33'd0;
      r_q     <= 32'd0;
      r_q1    <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else if (w_accept && !w_dz_start) begin
      r_op    <= op;
      r_neg_q <= A[31] ^ B[31];
      r_neg_r <= A[31];
      r_m     <= op ? w_b_mag : A;
      r_q     <= op ? w_a_mag : B;
      r_acc   <= 33'd0;
      r_q1    <= 1'b0;
      r_cnt   <= 6'd0;
    end else if (r_state == S_RUN) begin
      r_acc <= w_acc_nx;
      r_q   <= w_q_nx;
      r_q1  <= r_q[0];
      r_cnt <= r_cnt + 6'd1;
      if (w_last) begin
        r_hi <= w_hi_res;
        r_lo <= w_lo_res;
      end
    end
  end

  assign HI       = r_hi;
  assign LO       = r_lo;
  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_dz;

endmodule
